// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, EX redirect
// flush, multi-cycle DM wait with timeout abort, and stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             dm_req,
  input  logic             dm_ready,
  output logic             pc_wen,
  output logic             if_id_wen,
  output logic             if_id_clear,
  output logic             id_ex_wen,
  output logic             id_ex_clear,
  output logic             ex_mem_wen,
  output logic             ex_mem_clear,
  output logic             mem_wb_wen,
  output logic             mem_wb_clear,
  output logic             trap_req,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_WAIT = 2'd1, ST_ABORT = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [WC_W-1:0]   wait_cnt, wait_nxt;
  logic              mem_stall, load_use, use_run, flush_evt;

  assign mem_stall = dm_req & ~dm_ready;
  assign load_use  = ex_is_load & (ex_rd != 5'd0) &
                     ((id_rs1_used & (id_rs1 == ex_rd)) |
                      (id_rs2_used & (id_rs2 == ex_rd)));
  assign dbg_state = state;

  always_comb begin
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    use_run      = 1'b0;
    flush_evt    = 1'b0;
    pc_wen       = 1'b1;
    if_id_wen    = 1'b1;
    if_id_clear  = 1'b0;
    id_ex_wen    = 1'b1;
    id_ex_clear  = 1'b0;
    ex_mem_wen   = 1'b1;
    ex_mem_clear = 1'b0;
    mem_wb_wen   = 1'b1;
    mem_wb_clear = 1'b0;
    trap_req     = 1'b0;

    case (state)
      ST_RUN: begin
        if (mem_stall) begin
          state_nxt = ST_WAIT;
          wait_nxt  = WC_W'(1);
        end else begin
          use_run = 1'b1;
        end
      end
      ST_WAIT: begin
        // A dropped request is treated as completion so the pipe cannot lock up.
        if (dm_ready || !dm_req) begin
          use_run   = 1'b1;
          state_nxt = ST_RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
          state_nxt = ST_ABORT;
          wait_nxt  = '0;
        end else begin
          wait_nxt = wait_cnt + WC_W'(1);
        end
      end
      ST_ABORT: begin
        trap_req     = 1'b1;
        if_id_clear  = 1'b1;
        id_ex_clear  = 1'b1;
        ex_mem_clear = 1'b1;
        mem_wb_clear = 1'b1;
        flush_evt    = 1'b1;
        state_nxt    = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase

    if (use_run) begin
      // Redirect squashes whatever the load-use interlock would have held.
      if (ex_redirect) begin
        if_id_clear = 1'b1;
        id_ex_clear = 1'b1;
        flush_evt   = 1'b1;
      end else if (load_use) begin
        pc_wen      = 1'b0;
        if_id_wen   = 1'b0;
        id_ex_clear = 1'b1;
      end
    end else if (state != ST_ABORT) begin
      pc_wen       = 1'b0;
      if_id_wen    = 1'b0;
      id_ex_wen    = 1'b0;
      ex_mem_wen   = 1'b0;
      mem_wb_clear = 1'b1;
    end

    if_id_wen  = if_id_wen  | if_id_clear;
    id_ex_wen  = id_ex_wen  | id_ex_clear;
    ex_mem_wen = ex_mem_wen | ex_mem_clear;
    mem_wb_wen = mem_wb_wen | mem_wb_clear;

    if (rst) begin
      pc_wen       = 1'b0;
      if_id_wen    = 1'b1;
      if_id_clear  = 1'b1;
      id_ex_wen    = 1'b1;
      id_ex_clear  = 1'b1;
      ex_mem_wen   = 1'b1;
      ex_mem_clear = 1'b1;
      mem_wb_wen   = 1'b1;
      mem_wb_clear = 1'b1;
      trap_req     = 1'b0;
      flush_evt    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (!pc_wen)   stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4 and 8-bit counters.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 8;

  // {pc_wen, if_id_wen, if_id_clear, id_ex_wen, id_ex_clear,
  //  ex_mem_wen, ex_mem_clear, mem_wb_wen, mem_wb_clear, trap_req}
  localparam logic [9:0] C_NORM  = 10'b1101010100;
  localparam logic [9:0] C_LOADU = 10'b0001110100;
  localparam logic [9:0] C_REDIR = 10'b1111110100;
  localparam logic [9:0] C_STALL = 10'b0000000110;
  localparam logic [9:0] C_ABORT = 10'b1111111111;
  localparam logic [9:0] C_RESET = 10'b0111111110;

  logic clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_is_load, ex_redirect, dm_req, dm_ready;
  logic pc_wen, if_id_wen, if_id_clear, id_ex_wen, id_ex_clear;
  logic ex_mem_wen, ex_mem_clear, mem_wb_wen, mem_wb_clear, trap_req;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0] dbg_state;
  logic [9:0] ctl;

  int tests_run = 0;
  int tests_failed = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .dm_req(dm_req), .dm_ready(dm_ready),
    .pc_wen(pc_wen), .if_id_wen(if_id_wen), .if_id_clear(if_id_clear),
    .id_ex_wen(id_ex_wen), .id_ex_clear(id_ex_clear),
    .ex_mem_wen(ex_mem_wen), .ex_mem_clear(ex_mem_clear),
    .mem_wb_wen(mem_wb_wen), .mem_wb_clear(mem_wb_clear),
    .trap_req(trap_req), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .dbg_state(dbg_state)
  );

  assign ctl = {pc_wen, if_id_wen, if_id_clear, id_ex_wen, id_ex_clear,
                ex_mem_wen, ex_mem_clear, mem_wb_wen, mem_wb_clear, trap_req};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic [4:0] rs1, input logic rs1u, input logic [4:0] rs2,
                       input logic rs2u, input logic [4:0] rd, input logic ld,
                       input logic redir, input logic req, input logic rdy);
    id_rs1 = rs1; id_rs1_used = rs1u; id_rs2 = rs2; id_rs2_used = rs2u;
    ex_rd = rd; ex_is_load = ld; ex_redirect = redir; dm_req = req; dm_ready = rdy;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) tick();
    check("reset_ctl", 32'(ctl), 32'(C_RESET));
    check("reset_state", 32'(dbg_state), 32'd0);
    check("reset_stall", 32'(stall_cnt), 32'd0);
    check("reset_flush", 32'(flush_cnt), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_ctl", 32'(ctl), 32'(C_NORM));

    // Load-use on rs1 and rs2
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_rs1_ctl", 32'(ctl), 32'(C_LOADU));
    tick();
    check("lu_rs1_stall", 32'(stall_cnt), 32'd1);
    drive(5'd1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_rs2_ctl", 32'(ctl), 32'(C_LOADU));
    tick();
    check("lu_rs2_stall", 32'(stall_cnt), 32'd2);
    drive(5'd1, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_unused_ctl", 32'(ctl), 32'(C_NORM));
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_notload_ctl", 32'(ctl), 32'(C_NORM));

    // ex_rd = x0 never stalls
    drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("x0_ctl", 32'(ctl), 32'(C_NORM));
    tick();
    check("x0_stall", 32'(stall_cnt), 32'd2);

    // Redirect overrides load-use
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    check("redir_ctl", 32'(ctl), 32'(C_REDIR));
    tick();
    check("redir_flush", 32'(flush_cnt), 32'd1);
    check("redir_stall", 32'(stall_cnt), 32'd2);

    // DM wait released by dm_ready after 3 stall cycles
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("dm_run_ctl", 32'(ctl), 32'(C_STALL));
    tick();
    check("dm_wait_state", 32'(dbg_state), 32'd1);
    check("dm_w1_ctl", 32'(ctl), 32'(C_STALL));
    tick();
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    check("dm_w2_redir_ignored", 32'(ctl), 32'(C_STALL));
    tick();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("dm_ready_ctl", 32'(ctl), 32'(C_NORM));
    tick();
    check("dm_done_state", 32'(dbg_state), 32'd0);
    check("dm_done_stall", 32'(stall_cnt), 32'd5);
    check("dm_done_flush", 32'(flush_cnt), 32'd1);

    // Timeout: 1 RUN stall + 3 WAIT cycles, then ABORT
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("to_stall_ctl", 32'(ctl), 32'(C_STALL));
      tick();
    end
    check("to_abort_ctl", 32'(ctl), 32'(C_ABORT));
    check("to_abort_state", 32'(dbg_state), 32'd2);
    tick();
    check("to_after_state", 32'(dbg_state), 32'd0);
    check("to_after_trap", 32'(trap_req), 32'd0);
    check("to_flush", 32'(flush_cnt), 32'd2);
    check("to_stall", 32'(stall_cnt), 32'd9);
    idle();
    check("to_fetch_ctl", 32'(ctl), 32'(C_NORM));

    // dm_ready on the last permitted WAIT cycle wins over the timeout
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("tie_ctl", 32'(ctl), 32'(C_NORM));
    tick();
    check("tie_state", 32'(dbg_state), 32'd0);
    check("tie_stall", 32'(stall_cnt), 32'd12);
    check("tie_flush", 32'(flush_cnt), 32'd2);

    // dm_req dropping without dm_ready counts as completion
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    check("drop_ctl", 32'(ctl), 32'(C_NORM));
    tick();
    check("drop_state", 32'(dbg_state), 32'd0);
    check("drop_stall", 32'(stall_cnt), 32'd13);

    // Reset asserted in the middle of WAIT
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("mid_wait_state", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ctl", 32'(ctl), 32'(C_RESET));
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check("mid_rst_stall", 32'(stall_cnt), 32'd0);
    check("mid_rst_flush", 32'(flush_cnt), 32'd0);
    tick();
    check("rst_hold_stall", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    idle();

    // Stall counter wraps at 2^CNT_W
    drive(5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (255) tick();
    check("wrap_255", 32'(stall_cnt), 32'd255);
    tick();
    check("wrap_0", 32'(stall_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
